// File: rtl/coin_credit_bank_if.sv
// Controller/sensor side bundle of the coin credit bank: coin lines, bet handshake, payout, display.
// master = game controller and sensors, slave = the credit bank.
interface coin_credit_bank_if #(
    parameter int NCH    = 2,
    parameter int CW     = 10,
    parameter int PW     = 8,
    parameter int DIGITS = 3
);
    logic [NCH-1:0]    coin_n;
    logic              bet_req;
    logic              round_done;
    logic              payout_valid;
    logic [PW-1:0]     payout_amt;
    logic [CW-1:0]     credit;
    logic              busy;
    logic              bet_ok;
    logic              bet_rej;
    logic              coin_rej;
    logic [DIGITS-1:0] DIGIT;
    logic [6:0]        DISPLAY;

    modport master (
        output coin_n, bet_req, round_done, payout_valid, payout_amt,
        input  credit, busy, bet_ok, bet_rej, coin_rej, DIGIT, DISPLAY
    );

    modport slave (
        input  coin_n, bet_req, round_done, payout_valid, payout_amt,
        output credit, busy, bet_ok, bet_rej, coin_rej, DIGIT, DISPLAY
    );
endinterface

// File: rtl/coin_credit_bank.sv
// Coin credit accumulator with bet FSM, saturating payouts, sequential BCD and 7-seg scan.
// Coin->credit 3 edges, bet_req->bet_ok 2 edges, payout 1 edge; no backpressure, pulses are one cycle.
module coin_credit_bank #(
    parameter int               NCH       = 2,
    parameter logic [NCH*8-1:0] COIN_VAL  = {8'd10, 8'd5},
    parameter int               DIGITS    = 3,
    parameter int               CW        = 10,
    parameter int               BET       = 15,
    parameter int               PW        = 8,
    parameter int               LOCK_CYC  = 50_000_000,
    parameter int               SCAN_BITS = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    coin_credit_bank_if.slave bus
);
    localparam int MAX  = (10 ** DIGITS) - 1;
    localparam int AW   = CW + PW + 1;
    localparam int LW   = $clog2(LOCK_CYC + 1);
    localparam int CNTW = $clog2(CW + 1);
    localparam int BW   = DIGITS * 4;
    localparam int DGW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    // ---------------- coin synchronisers and lockouts ----------------
    logic [NCH-1:0] sync1_q, sync2_q, sync3_q;
    logic [NCH-1:0] fall, cand;
    logic [LW-1:0]  lock_q [NCH];
    logic [LW-1:0]  lock_d [NCH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            sync3_q <= '1;
        end else begin
            sync1_q <= bus.coin_n;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign fall = sync3_q & ~sync2_q;

    // A refused coin still arms the lockout so a bouncing sensor cannot retry.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NCH; i++) begin
            lock_d[i] = lock_q[i];
            cand[i]   = fall[i] && (lock_q[i] == '0);
            if (cand[i])
                lock_d[i] = LW'(LOCK_CYC);
            else if (lock_q[i] != '0)
                lock_d[i] = lock_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) lock_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) lock_q[i] <= lock_d[i];
        end
    end

    // ---------------- bet request edge detect and FSM ----------------
    logic   req_s_q, req_p_q, bet_rise;
    state_t state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic   credit_ok, bet_acc, bet_refuse, busy_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s_q <= 1'b0;
            req_p_q <= 1'b0;
        end else begin
            req_s_q <= bus.bet_req;
            req_p_q <= req_s_q;
        end
    end

    assign bet_rise  = req_s_q & ~req_p_q;
    assign credit_ok = (credit_q >= CW'(BET));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bet_rise && credit_ok) state_d = S_BUSY;
            S_BUSY:  if (bus.round_done)        state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bet_acc    = 1'b0;
        bet_refuse = 1'b0;
        busy_int   = 1'b0;
        case (state_q)
            S_IDLE: begin
                bet_acc    = bet_rise && credit_ok;
                bet_refuse = bet_rise && !credit_ok;
            end
            S_BUSY:  busy_int = 1'b1;
            default: busy_int = 1'b0;
        endcase
    end

    // ---------------- credit datapath ----------------
    logic [AW-1:0] base, coinsum, with_coin, after_coin, with_pay;
    logic          coin_refuse;

    always_comb begin
        coinsum = '0;
        for (int i = 0; i < NCH; i++)
            if (cand[i]) coinsum = coinsum + AW'(COIN_VAL[8*i +: 8]);
        base        = AW'(credit_q) - (bet_acc ? AW'(BET) : AW'(0));
        with_coin   = base + coinsum;
        coin_refuse = (cand != '0) && (with_coin > AW'(MAX));
        after_coin  = coin_refuse ? base : with_coin;
        with_pay    = after_coin + (bus.payout_valid ? AW'(bus.payout_amt) : AW'(0));
        credit_d    = (with_pay > AW'(MAX)) ? CW'(MAX) : with_pay[CW-1:0];
    end

    logic bet_ok_q, bet_rej_q, coin_rej_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q   <= '0;
            bet_ok_q   <= 1'b0;
            bet_rej_q  <= 1'b0;
            coin_rej_q <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            bet_ok_q   <= bet_acc;
            bet_rej_q  <= bet_refuse;
            coin_rej_q <= coin_refuse;
        end
    end

    // ---------------- iterative double-dabble ----------------
    // Step 0 samples credit; steps 1..CW each adjust and shift one bit in.
    logic [CNTW-1:0]  cnt_q;
    logic [CW-1:0]    sh_q;
    logic [BW-1:0]    work_q, work_adj, bcd_q;
    logic [BW+CW-1:0] dd_nxt;

    always_comb begin
        work_adj = work_q;
        for (int d = 0; d < DIGITS; d++)
            if (work_q[4*d +: 4] >= 4'd5) work_adj[4*d +: 4] = work_q[4*d +: 4] + 4'd3;
        dd_nxt = {work_adj, sh_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sh_q   <= '0;
            work_q <= '0;
            bcd_q  <= '0;
        end else if (cnt_q == '0) begin
            sh_q   <= credit_q;
            work_q <= '0;
            cnt_q  <= CNTW'(1);
        end else begin
            sh_q   <= dd_nxt[CW-1:0];
            work_q <= dd_nxt[BW+CW-1:CW];
            if (cnt_q == CNTW'(CW)) begin
                bcd_q <= dd_nxt[BW+CW-1:CW];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // ---------------- display scan ----------------
    logic [SCAN_BITS-1:0] div_q;
    logic [DGW-1:0]       dig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            dig_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
            if (&div_q)
                dig_q <= (dig_q == DGW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign bus.credit   = credit_q;
    assign bus.busy     = busy_int;
    assign bus.bet_ok   = bet_ok_q;
    assign bus.bet_rej  = bet_rej_q;
    assign bus.coin_rej = coin_rej_q;
    assign bus.DIGIT    = ~(DIGITS'(1) << dig_q);
    assign bus.DISPLAY  = seg7(bcd_q[{dig_q, 2'b00} +: 4]);
endmodule

// File: tb/tb_coin_credit_bank.sv
module tb_coin_credit_bank;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    coin_credit_bank_if #(.NCH(2), .CW(10), .PW(8), .DIGITS(3)) bus ();

    coin_credit_bank #(
        .NCH(2), .COIN_VAL({8'd10, 8'd5}), .DIGITS(3), .CW(10), .BET(15),
        .PW(8), .LOCK_CYC(16), .SCAN_BITS(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n            = 1'b0;
        bus.coin_n       = '1;
        bus.bet_req      = 1'b0;
        bus.round_done   = 1'b0;
        bus.payout_valid = 1'b0;
        bus.payout_amt   = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic pay(input int amt);
        bus.payout_valid = 1'b1;
        bus.payout_amt   = 8'(amt);
        tick(1);
        bus.payout_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        total++; if (bus.credit !== 10'd0) begin bad++; $display("FAIL rst_credit got %0d want 0", bus.credit); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        total++; if ({bus.bet_ok, bus.bet_rej, bus.coin_rej} !== 3'b000) begin bad++; $display("FAIL rst_pulses got %b want 000", {bus.bet_ok, bus.bet_rej, bus.coin_rej}); end
        total++; if (bus.DIGIT !== 3'b110) begin bad++; $display("FAIL rst_digit got %b want 110", bus.DIGIT); end
        total++; if (bus.DISPLAY !== 7'b1000000) begin bad++; $display("FAIL rst_display got %b want 1000000", bus.DISPLAY); end
    endtask

    task automatic test_coins;
        do_reset;
        bus.coin_n[0] = 1'b0;
        tick(2);
        total++; if (bus.credit !== 10'd0) begin bad++; $display("FAIL coin_early got %0d want 0", bus.credit); end
        tick(1);
        total++; if (bus.credit !== 10'd5) begin bad++; $display("FAIL coin_latency got %0d want 5", bus.credit); end
        tick(97);
        total++; if (bus.credit !== 10'd5) begin bad++; $display("FAIL coin_hold got %0d want 5", bus.credit); end
        bus.coin_n[0] = 1'b1;
        tick(20);
        bus.coin_n[1] = 1'b0;
        tick(100);
        bus.coin_n[1] = 1'b1;
        total++; if (bus.credit !== 10'd15) begin bad++; $display("FAIL coin_ch1 got %0d want 15", bus.credit); end
        tick(20);
    endtask

    task automatic test_overflow;
        int seen;
        do_reset;
        pay(255); pay(255); pay(255); pay(230);
        total++; if (bus.credit !== 10'd995) begin bad++; $display("FAIL ovf_setup got %0d want 995", bus.credit); end
        bus.coin_n[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(1); if (bus.coin_rej === 1'b1) seen++; end
        bus.coin_n[1] = 1'b1;
        total++; if (seen != 1) begin bad++; $display("FAIL coin_rej_pulse got %0d cycles want 1", seen); end
        total++; if (bus.credit !== 10'd995) begin bad++; $display("FAIL ovf_credit got %0d want 995", bus.credit); end
        // drop to 980 so a retry inside the lockout would visibly add if not ignored
        bus.bet_req = 1'b1;
        tick(2);
        total++; if (bus.credit !== 10'd980 || bus.bet_ok !== 1'b1) begin bad++; $display("FAIL ovf_bet got %0d/%b want 980/1", bus.credit, bus.bet_ok); end
        bus.bet_req = 1'b0;
        tick(1);
        bus.coin_n[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(1); if (bus.coin_rej === 1'b1) seen++; end
        bus.coin_n[1] = 1'b1;
        total++; if (bus.credit !== 10'd980 || seen != 0) begin bad++; $display("FAIL lockout_retry got %0d rej=%0d want 980 rej=0", bus.credit, seen); end
        bus.round_done = 1'b1;
        tick(1);
        bus.round_done = 1'b0;
        tick(30);
        bus.coin_n[1] = 1'b0;
        tick(4);
        bus.coin_n[1] = 1'b1;
        tick(2);
        total++; if (bus.credit !== 10'd990) begin bad++; $display("FAIL lockout_expired got %0d want 990", bus.credit); end
    endtask

    task automatic test_bet;
        do_reset;
        pay(14);
        bus.bet_req = 1'b1;
        tick(1);
        total++; if (bus.bet_rej !== 1'b0) begin bad++; $display("FAIL rej_early got %b want 0", bus.bet_rej); end
        tick(1);
        total++; if ({bus.bet_rej, bus.bet_ok, bus.busy} !== 3'b100 || bus.credit !== 10'd14) begin bad++; $display("FAIL bet_rej got rej/ok/busy=%b credit=%0d want 100 credit=14", {bus.bet_rej, bus.bet_ok, bus.busy}, bus.credit); end
        tick(1);
        total++; if (bus.bet_rej !== 1'b0) begin bad++; $display("FAIL rej_width got %b want 0", bus.bet_rej); end
        bus.bet_req = 1'b0;
        tick(1);
        bus.coin_n[0] = 1'b0;
        tick(4);
        bus.coin_n[0] = 1'b1;
        tick(1);
        total++; if (bus.credit !== 10'd19) begin bad++; $display("FAIL bet_coin got %0d want 19", bus.credit); end
        bus.bet_req = 1'b1;
        tick(2);
        total++; if ({bus.bet_ok, bus.busy} !== 2'b11 || bus.credit !== 10'd4) begin bad++; $display("FAIL bet_ok got ok/busy=%b credit=%0d want 11 credit=4", {bus.bet_ok, bus.busy}, bus.credit); end
        tick(1);
        total++; if (bus.bet_ok !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL ok_width got ok=%b busy=%b want 0 1", bus.bet_ok, bus.busy); end
        bus.bet_req = 1'b0;
        tick(1);
    endtask

    task automatic test_busy;
        int seen;
        bus.bet_req = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin tick(1); if (bus.bet_ok === 1'b1 || bus.bet_rej === 1'b1) seen++; end
        bus.bet_req = 1'b0;
        total++; if (seen != 0 || bus.credit !== 10'd4 || bus.busy !== 1'b1) begin bad++; $display("FAIL busy_ignore got pulses=%0d credit=%0d busy=%b want 0 4 1", seen, bus.credit, bus.busy); end
        tick(1);
        pay(200);
        total++; if (bus.credit !== 10'd204) begin bad++; $display("FAIL busy_payout got %0d want 204", bus.credit); end
        // bet edge arriving in the same cycle as round_done must not start a new round
        bus.bet_req = 1'b1;
        tick(1);
        bus.round_done = 1'b1;
        tick(1);
        bus.round_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin if (bus.bet_ok === 1'b1 || bus.bet_rej === 1'b1) seen++; tick(1); end
        total++; if (bus.busy !== 1'b0 || seen != 0 || bus.credit !== 10'd204) begin bad++; $display("FAIL round_done got busy=%b pulses=%0d credit=%0d want 0 0 204", bus.busy, seen, bus.credit); end
        bus.bet_req = 1'b0;
        tick(1);
        bus.bet_req = 1'b1;
        tick(2);
        total++; if (bus.bet_ok !== 1'b1 || bus.credit !== 10'd189) begin bad++; $display("FAIL idle_again got ok=%b credit=%0d want 1 189", bus.bet_ok, bus.credit); end
        bus.bet_req = 1'b0;
        tick(1);
    endtask

    task automatic test_same_cycle;
        do_reset;
        pay(255); pay(255); pay(255); pay(225);
        total++; if (bus.credit !== 10'd990) begin bad++; $display("FAIL same_setup got %0d want 990", bus.credit); end
        bus.coin_n = 2'b00;
        tick(1);
        bus.bet_req = 1'b1;
        tick(1);
        bus.payout_valid = 1'b1;
        bus.payout_amt   = 8'd8;
        tick(1);
        bus.payout_valid = 1'b0;
        total++; if (bus.credit !== 10'd998 || bus.bet_ok !== 1'b1 || bus.coin_rej !== 1'b0) begin bad++; $display("FAIL same_cycle got credit=%0d ok=%b rej=%b want 998 1 0", bus.credit, bus.bet_ok, bus.coin_rej); end
        bus.coin_n  = 2'b11;
        bus.bet_req = 1'b0;
        tick(1);
        pay(255);
        total++; if (bus.credit !== 10'd999) begin bad++; $display("FAIL payout_sat got %0d want 999", bus.credit); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        bus.coin_n[0] = 1'b0;
        tick(4);
        pay(20);
        bus.bet_req = 1'b1;
        tick(2);
        total++; if (bus.busy !== 1'b1 || bus.credit !== 10'd10) begin bad++; $display("FAIL mid_setup got busy=%b credit=%0d want 1 10", bus.busy, bus.credit); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.credit !== 10'd0 || bus.busy !== 1'b0 || bus.DIGIT !== 3'b110 || bus.DISPLAY !== 7'b1000000) begin bad++; $display("FAIL mid_reset got credit=%0d busy=%b digit=%b disp=%b want 0 0 110 1000000", bus.credit, bus.busy, bus.DIGIT, bus.DISPLAY); end
        bus.coin_n[0] = 1'b1;
        bus.bet_req   = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        bus.coin_n[0] = 1'b0;
        tick(4);
        bus.coin_n[0] = 1'b1;
        tick(1);
        total++; if (bus.credit !== 10'd5) begin bad++; $display("FAIL mid_lockout_clear got %0d want 5", bus.credit); end
    endtask

    task automatic test_scan;
        logic [2:0] prev;
        bit         found;
        do_reset;
        pay(255); pay(152);
        total++; if (bus.credit !== 10'd407) begin bad++; $display("FAIL scan_setup got %0d want 407", bus.credit); end
        tick(40);
        found = 1'b0;
        prev  = bus.DIGIT;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (bus.DIGIT === 3'b110 && prev !== 3'b110) found = 1'b1;
            prev = bus.DIGIT;
        end
        total++; if (!found) begin bad++; $display("FAIL scan_sync got no digit0 entry want one within 20 cycles"); end
        total++; if (bus.DIGIT !== 3'b110 || bus.DISPLAY !== 7'b1111000) begin bad++; $display("FAIL scan_d0 got %b/%b want 110/1111000", bus.DIGIT, bus.DISPLAY); end
        tick(4);
        total++; if (bus.DIGIT !== 3'b101 || bus.DISPLAY !== 7'b1000000) begin bad++; $display("FAIL scan_d1 got %b/%b want 101/1000000", bus.DIGIT, bus.DISPLAY); end
        tick(4);
        total++; if (bus.DIGIT !== 3'b011 || bus.DISPLAY !== 7'b0011001) begin bad++; $display("FAIL scan_d2 got %b/%b want 011/0011001", bus.DIGIT, bus.DISPLAY); end
        tick(4);
        total++; if (bus.DIGIT !== 3'b110 || bus.DISPLAY !== 7'b1111000) begin bad++; $display("FAIL scan_wrap got %b/%b want 110/1111000", bus.DIGIT, bus.DISPLAY); end
    endtask

    initial begin
        test_reset;
        test_coins;
        test_overflow;
        test_bet;
        test_busy;
        test_same_cycle;
        test_reset_mid;
        test_scan;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
